// File: rtl/wavegen_pkg.sv
// +----------------------------------------------------------------------+
// | wavegen_pkg : shared types and defaults for the multi-mode wavegen   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package wavegen_pkg;

   localparam int DEF_WIDTH     = 8;
   localparam int DEF_DIV_WIDTH = 24;
   localparam int DEF_DIV       = 390;

   typedef enum logic [1:0] {
      MODE_RAMP_UP   = 2'd0,
      MODE_RAMP_DOWN = 2'd1,
      MODE_TRIANGLE  = 2'd2,
      MODE_SQUARE    = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_DOWN = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   typedef struct packed {
      mode_e                    mode;
      logic [DEF_DIV_WIDTH-1:0] div;
      logic [DEF_WIDTH-1:0]     amp;
   } cfg_t;

endpackage

`default_nettype wire

// File: rtl/wavegen_multi_if.sv
// +----------------------------------------------------------------------+
// | wavegen_multi_if : valid/ready configuration port of wavegen_multi   |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface wavegen_multi_if #(
   parameter int WIDTH     = 8,
   parameter int DIV_WIDTH = 24
);
   import wavegen_pkg::*;

   logic                 cfg_valid;
   logic                 cfg_ready;
   mode_e                cfg_mode;
   logic [DIV_WIDTH-1:0] cfg_div;
   logic [WIDTH-1:0]     cfg_amp;

   modport master (output cfg_valid, cfg_mode, cfg_div, cfg_amp, input cfg_ready);
   modport slave  (input cfg_valid, cfg_mode, cfg_div, cfg_amp, output cfg_ready);

endinterface

`default_nettype wire

// File: rtl/wavegen_multi_pwm.sv
// +----------------------------------------------------------------------+
// | wavegen_pwm : free-running carrier compared against the DAC code     |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module wavegen_pwm #(
   parameter int WIDTH              = 8,
   parameter int ZERO_WHEN_DISABLED = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             run,
   input  logic [WIDTH-1:0] code,
   output logic             pwm_out
);

   logic [WIDTH-1:0] carrier;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         carrier <= '0;
      end else if (run) begin
         carrier <= carrier + WIDTH'(1);
      end else if (ZERO_WHEN_DISABLED != 0) begin
         carrier <= '0;
      end
   end

   // Strict compare: full-scale code still leaves one low slot per carrier period.
   assign pwm_out = run && (carrier < code);

endmodule

`default_nettype wire

// File: rtl/wavegen_multi.sv
// +----------------------------------------------------------------------+
// | wavegen_multi : ramp/triangle/square generator with R-2R and PWM out |
// | Optional one-shot mode under macro WAVEGEN_ONESHOT_EN                |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module wavegen_multi
   import wavegen_pkg::*;
#(
   parameter int WIDTH              = DEF_WIDTH,
   parameter int DIV_WIDTH          = DEF_DIV_WIDTH,
   parameter int DEFAULT_DIV        = DEF_DIV,
   parameter int ZERO_WHEN_DISABLED = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   wavegen_multi_if.slave    cfg,
`ifdef WAVEGEN_ONESHOT_EN
   input  logic              oneshot,
   output logic              done,
`endif
   output logic [WIDTH-1:0]  dac_code,
   output logic              pwm_out,
   output logic              period_start,
   output logic [1:0]        active_mode
);

   typedef struct packed {
      mode_e                mode;
      logic [DIV_WIDTH-1:0] div;
      logic [WIDTH-1:0]     amp;
   } cfg_rec_t;

   state_e               state, state_nxt;
   cfg_rec_t             act_cfg, pend_cfg, eff_cfg, bus_cfg;
   logic                 pend_full;
   logic [DIV_WIDTH-1:0] div_cnt, div_nxt;
   logic [WIDTH-1:0]     step_cnt, step_nxt, code_nxt;
   logic                 ps_nxt, running, tick, wrap, restart, load, take, armed;

   assign bus_cfg       = '{mode: cfg.cfg_mode, div: cfg.cfg_div, amp: cfg.cfg_amp};
   assign take          = cfg.cfg_valid && !pend_full;
   assign cfg.cfg_ready = !pend_full;
   assign eff_cfg       = pend_full ? pend_cfg : act_cfg;
   assign running       = (state == ST_UP) || (state == ST_DOWN);
   assign tick          = running && (div_cnt == act_cfg.div);
   assign active_mode   = act_cfg.mode;

   always_comb begin
      state_nxt = state;
      code_nxt  = dac_code;
      step_nxt  = step_cnt;
      div_nxt   = div_cnt;
      ps_nxt    = 1'b0;
      wrap      = 1'b0;
      restart   = 1'b0;
      case (state)
         ST_IDLE: restart = enable;
         ST_UP, ST_DOWN: begin
            if (!enable) begin
               state_nxt = ST_IDLE;
               if (ZERO_WHEN_DISABLED != 0) begin
                  code_nxt = '0;
                  div_nxt  = '0;
               end
            end else if (!tick) begin
               div_nxt = div_cnt + DIV_WIDTH'(1);
            end else begin
               div_nxt = '0;
               case (act_cfg.mode)
                  MODE_RAMP_UP: begin
                     if (dac_code == act_cfg.amp) wrap = 1'b1;
                     else code_nxt = dac_code + WIDTH'(1);
                  end
                  MODE_RAMP_DOWN: begin
                     if (dac_code == '0) wrap = 1'b1;
                     else code_nxt = dac_code - WIDTH'(1);
                  end
                  MODE_TRIANGLE: begin
                     if (state == ST_UP) begin
                        // amp of 0 or 1 has no interior descending codes
                        if (dac_code != act_cfg.amp) begin
                           code_nxt = dac_code + WIDTH'(1);
                        end else if (act_cfg.amp <= WIDTH'(1)) begin
                           wrap = 1'b1;
                        end else begin
                           state_nxt = ST_DOWN;
                           code_nxt  = act_cfg.amp - WIDTH'(1);
                        end
                     end else if (dac_code <= WIDTH'(1)) begin
                        wrap = 1'b1;
                     end else begin
                        code_nxt = dac_code - WIDTH'(1);
                     end
                  end
                  MODE_SQUARE: begin
                     if (step_cnt != act_cfg.amp) begin
                        step_nxt = step_cnt + WIDTH'(1);
                     end else if (state == ST_UP) begin
                        step_nxt  = '0;
                        state_nxt = ST_DOWN;
                        code_nxt  = '0;
                     end else begin
                        wrap = 1'b1;
                     end
                  end
               endcase
            end
         end
         default: if (!enable) state_nxt = ST_IDLE;
      endcase

      // A fresh period always starts from the pending slot if one is waiting.
      load = restart || (wrap && !armed);
      if (load) begin
         ps_nxt    = 1'b1;
         div_nxt   = '0;
         step_nxt  = '0;
         state_nxt = (eff_cfg.mode == MODE_RAMP_DOWN) ? ST_DOWN : ST_UP;
         code_nxt  = (eff_cfg.mode == MODE_RAMP_DOWN || eff_cfg.mode == MODE_SQUARE)
                     ? eff_cfg.amp : '0;
      end else if (wrap) begin
         state_nxt = ST_DONE;
         code_nxt  = '0;
         div_nxt   = '0;
         step_nxt  = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         act_cfg      <= '{mode: MODE_RAMP_UP, div: DIV_WIDTH'(DEFAULT_DIV), amp: '1};
         pend_cfg     <= '0;
         pend_full    <= 1'b0;
         div_cnt      <= '0;
         step_cnt     <= '0;
         dac_code     <= '0;
         period_start <= 1'b0;
      end else begin
         state        <= state_nxt;
         div_cnt      <= div_nxt;
         step_cnt     <= step_nxt;
         dac_code     <= code_nxt;
         period_start <= ps_nxt;
         if (load) begin
            act_cfg   <= eff_cfg;
            pend_full <= 1'b0;
         end
         // An offer accepted on a boundary edge waits for the following boundary.
         if (take) begin
            pend_cfg  <= bus_cfg;
            pend_full <= 1'b1;
         end
      end
   end

`ifdef WAVEGEN_ONESHOT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         armed <= 1'b0;
      end else if (load) begin
         armed <= oneshot;
      end else if (wrap) begin
         armed <= 1'b0;
      end
   end

   assign done = (state == ST_DONE);
`else
   assign armed = 1'b0;
`endif

   wavegen_pwm #(
      .WIDTH              (WIDTH),
      .ZERO_WHEN_DISABLED (ZERO_WHEN_DISABLED)
   ) u_pwm (
      .clk     (clk),
      .reset_n (reset_n),
      .run     (state != ST_IDLE),
      .code    (dac_code),
      .pwm_out (pwm_out)
   );

endmodule

`default_nettype wire

// File: tb/tb_wavegen_multi.sv
// +----------------------------------------------------------------------+
// | tb_wavegen_multi : directed vector bench for wavegen_multi           |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_wavegen_multi;
   import wavegen_pkg::*;

   localparam int WIDTH     = 8;
   localparam int DIV_WIDTH = 24;

   logic             clk     = 1'b0;
   logic             reset_n = 1'b0;
   logic             enable  = 1'b0;
   logic [WIDTH-1:0] dac_code;
   logic             pwm_out;
   logic             period_start;
   logic [1:0]       active_mode;
   int               errors  = 0;
   int               checks  = 0;

   wavegen_multi_if #(.WIDTH(WIDTH), .DIV_WIDTH(DIV_WIDTH)) cfg_bus ();

`ifdef WAVEGEN_ONESHOT_EN
   logic oneshot = 1'b0;
   logic done;
`endif

   wavegen_multi #(
      .WIDTH              (WIDTH),
      .DIV_WIDTH          (DIV_WIDTH),
      .DEFAULT_DIV        (390),
      .ZERO_WHEN_DISABLED (1)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .cfg          (cfg_bus),
`ifdef WAVEGEN_ONESHOT_EN
      .oneshot      (oneshot),
      .done         (done),
`endif
      .dac_code     (dac_code),
      .pwm_out      (pwm_out),
      .period_start (period_start),
      .active_mode  (active_mode)
   );

   always #5 clk = ~clk;

   typedef struct {
      mode_e mode;
      int    div;
      int    amp;
      int    k;
      int    code;
      int    ps;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input mode_e m, input int d, input int a, input int k,
                          input int c, input int p);
      vec_t v;
      v.mode = m; v.div = d; v.amp = a; v.k = k; v.code = c; v.ps = p;
      vecs.push_back(v);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic send_cfg(input mode_e m, input int d, input int a);
      int n = 0;
      while (cfg_bus.cfg_ready !== 1'b1 && n < 2000) begin
         step(1);
         n++;
      end
      chk("cfg_ready_wait", {31'd0, cfg_bus.cfg_ready}, 1);
      cfg_bus.cfg_valid = 1'b1;
      cfg_bus.cfg_mode  = m;
      cfg_bus.cfg_div   = DIV_WIDTH'(d);
      cfg_bus.cfg_amp   = WIDTH'(a);
      step(1);
      cfg_bus.cfg_valid = 1'b0;
   endtask

   task automatic start_run();
      enable = 1'b1;
      step(1);
   endtask

   task automatic stop_run();
      enable = 1'b0;
      step(2);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int ones;
      cfg_bus.cfg_valid = 1'b0;
      cfg_bus.cfg_mode  = MODE_RAMP_UP;
      cfg_bus.cfg_div   = '0;
      cfg_bus.cfg_amp   = '0;

      // mode, div, amp, cycles after start, expected code, expected period_start
      add_vec(MODE_RAMP_UP,   0, 255,   0,   0, 1);
      add_vec(MODE_RAMP_UP,   0, 255, 128, 128, 0);
      add_vec(MODE_RAMP_UP,   0, 255, 255, 255, 0);
      add_vec(MODE_RAMP_UP,   0, 255, 256,   0, 1);
      add_vec(MODE_TRIANGLE,  1,   4,   0,   0, 1);
      add_vec(MODE_TRIANGLE,  1,   4,   1,   0, 0);
      add_vec(MODE_TRIANGLE,  1,   4,   8,   4, 0);
      add_vec(MODE_TRIANGLE,  1,   4,  10,   3, 0);
      add_vec(MODE_TRIANGLE,  1,   4,  15,   1, 0);
      add_vec(MODE_TRIANGLE,  1,   4,  16,   0, 1);
      add_vec(MODE_SQUARE,    0,   3,   0,   3, 1);
      add_vec(MODE_SQUARE,    0,   3,   3,   3, 0);
      add_vec(MODE_SQUARE,    0,   3,   4,   0, 0);
      add_vec(MODE_SQUARE,    0,   3,   7,   0, 0);
      add_vec(MODE_SQUARE,    0,   3,   8,   3, 1);
      add_vec(MODE_TRIANGLE,  0,   1,   1,   1, 0);
      add_vec(MODE_TRIANGLE,  0,   1,   2,   0, 1);
      add_vec(MODE_TRIANGLE,  0,   1,   3,   1, 0);
      add_vec(MODE_TRIANGLE,  0,   0,   5,   0, 1);
      add_vec(MODE_RAMP_DOWN, 2,  10,   0,  10, 1);
      add_vec(MODE_RAMP_DOWN, 2,  10,   3,   9, 0);
      add_vec(MODE_RAMP_DOWN, 2,  10,  32,   0, 0);
      add_vec(MODE_RAMP_DOWN, 2,  10,  33,  10, 1);

      // Reset values
      step(2);
      chk("rst dac_code", dac_code, 0);
      chk("rst pwm_out", pwm_out, 0);
      chk("rst period_start", period_start, 0);
      chk("rst cfg_ready", cfg_bus.cfg_ready, 1);
      chk("rst active_mode", active_mode, 0);
      reset_n = 1'b1;
      step(1);

      // Default configuration: ramp-up, one step every 391 clocks
      start_run();
      chk("dflt k0 code", dac_code, 0);
      chk("dflt k0 ps", period_start, 1);
      step(390);
      chk("dflt k390 code", dac_code, 0);
      step(1);
      chk("dflt k391 code", dac_code, 1);
      stop_run();

      for (int i = 0; i < vecs.size(); i++) begin
         stop_run();
         send_cfg(vecs[i].mode, vecs[i].div, vecs[i].amp);
         start_run();
         step(vecs[i].k);
         chk($sformatf("vec%0d code", i), dac_code, vecs[i].code);
         chk($sformatf("vec%0d period_start", i), period_start, vecs[i].ps);
         chk($sformatf("vec%0d active_mode", i), active_mode, 32'(vecs[i].mode));
      end

      // PWM duty over one full carrier period at a constant code
      stop_run();
      send_cfg(MODE_SQUARE, 255, 128);
      start_run();
      ones = 0;
      for (int i = 0; i < 256; i++) begin
         ones += int'(pwm_out);
         step(1);
      end
      chk("pwm duty code128", ones, 128);
      stop_run();
      send_cfg(MODE_SQUARE, 255, 255);
      start_run();
      ones = 0;
      for (int i = 0; i < 256; i++) begin
         ones += int'(pwm_out);
         step(1);
      end
      chk("pwm duty code255", ones, 255);

      // Mid-period reconfiguration takes effect at the boundary
      stop_run();
      send_cfg(MODE_RAMP_UP, 0, 20);
      start_run();
      step(5);
      send_cfg(MODE_RAMP_DOWN, 0, 10);
      chk("mid k6 cfg_ready", cfg_bus.cfg_ready, 0);
      step(14);
      chk("mid k20 code", dac_code, 20);
      chk("mid k20 cfg_ready", cfg_bus.cfg_ready, 0);
      chk("mid k20 active_mode", active_mode, 0);
      step(1);
      chk("mid k21 code", dac_code, 10);
      chk("mid k21 ps", period_start, 1);
      chk("mid k21 active_mode", active_mode, 1);
      step(1);
      chk("mid k22 code", dac_code, 9);
      chk("mid k22 cfg_ready", cfg_bus.cfg_ready, 1);

      // Offer accepted on the boundary edge waits one more period
      stop_run();
      send_cfg(MODE_RAMP_UP, 0, 3);
      start_run();
      step(3);
      send_cfg(MODE_RAMP_DOWN, 0, 5);
      chk("bnd k4 code", dac_code, 0);
      chk("bnd k4 ps", period_start, 1);
      chk("bnd k4 active_mode", active_mode, 0);
      step(4);
      chk("bnd k8 code", dac_code, 5);
      chk("bnd k8 ps", period_start, 1);
      chk("bnd k8 active_mode", active_mode, 1);

      // Disable at code 7, then restart
      stop_run();
      send_cfg(MODE_RAMP_UP, 0, 255);
      start_run();
      step(7);
      chk("dis k7 code", dac_code, 7);
      enable = 1'b0;
      step(1);
      chk("dis code", dac_code, 0);
      chk("dis pwm", pwm_out, 0);
      chk("dis ps", period_start, 0);
      enable = 1'b1;
      step(1);
      chk("reen code", dac_code, 0);
      chk("reen ps", period_start, 1);
      step(1);
      chk("reen k1 code", dac_code, 1);

      // Asynchronous reset mid-triangle with a pending config
      stop_run();
      send_cfg(MODE_TRIANGLE, 1, 4);
      start_run();
      step(5);
      chk("trirst k5 code", dac_code, 2);
      send_cfg(MODE_SQUARE, 0, 2);
      chk("trirst pend ready", cfg_bus.cfg_ready, 0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst code", dac_code, 0);
      chk("arst cfg_ready", cfg_bus.cfg_ready, 1);
      chk("arst active_mode", active_mode, 0);
      chk("arst pwm", pwm_out, 0);
      reset_n = 1'b1;
      step(1);
      chk("post-rst k0 code", dac_code, 0);
      chk("post-rst k0 ps", period_start, 1);
      chk("post-rst k0 active_mode", active_mode, 0);
      step(391);
      chk("post-rst k391 code", dac_code, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
